// File: rtl/param_sync_fifo_if.sv
// Handshake/data bundle for param_sync_fifo.
// PARAM_SYNC_FIFO_ERR_EN adds the sticky overflow/underflow outputs.
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  read;
    logic                  write;
    logic                  flush;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CW-1:0]         count;
`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output read, write, flush, dataIn,
        input  dataOut, empty, full, almost_empty, almost_full, count,
        input  overflow, underflow
    );
    modport slave (
        input  read, write, flush, dataIn,
        output dataOut, empty, full, almost_empty, almost_full, count,
        output overflow, underflow
    );
`else
    modport master (
        output read, write, flush, dataIn,
        input  dataOut, empty, full, almost_empty, almost_full, count
    );
    modport slave (
        input  read, write, flush, dataIn,
        output dataOut, empty, full, almost_empty, almost_full, count
    );
`endif
endinterface

// File: rtl/param_sync_fifo.sv
// Parametrised synchronous FIFO with occupancy count, thresholds, flush and registered read port.
// Define PARAM_SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int AE_THRESH  = 1,
    parameter int AF_THRESH  = 7
) (
    input logic               clk,
    input logic               nRst,
    param_sync_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic empty, full, rd_ok, wr_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Reset and flush both suppress acceptance, so storage is never written in those cycles.
    assign rd_ok = nRst & ~bus.flush & bus.read & ~empty;
    assign wr_ok = nRst & ~bus.flush & bus.write & (~full | bus.read);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                data_d   = mem_q[rd_ptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= bus.dataIn;
        end
    end

    assign bus.dataOut      = data_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.flush) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (bus.write & full & ~bus.read) ovf_d = 1'b1;
            if (bus.read & empty)             unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif
endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios then random traffic
// compared against a queue-based reference model.
module tb_param_sync_fifo;
    localparam int DW    = 128;
    localparam int DEPTH = 8;
    localparam int AE    = 1;
    localparam int AF    = 7;

    logic clk;
    logic nRst;
    int   n_checks;
    int   n_errors;

    param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    param_sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AE_THRESH (AE),
        .AF_THRESH (AF)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mdl_q [$];
    logic [DW-1:0] mdl_dout;
    logic          mdl_ovf;
    logic          mdl_unf;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic rd, input logic wr,
                              input logic fl, input logic [DW-1:0] din);
        int  sz;
        logic rdok, wrok;
        sz = mdl_q.size();
        if (!rst_n) begin
            mdl_q.delete();
            mdl_dout = '0;
            mdl_ovf  = 1'b0;
            mdl_unf  = 1'b0;
        end else if (fl) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
            mdl_unf = 1'b0;
        end else begin
            rdok = rd && (sz > 0);
            wrok = wr && ((sz < DEPTH) || rd);
            if (wr && sz == DEPTH && !rd) mdl_ovf = 1'b1;
            if (rd && sz == 0)            mdl_unf = 1'b1;
            if (rdok) mdl_dout = mdl_q.pop_front();
            if (wrok) mdl_q.push_back(din);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = mdl_q.size();
        check("count",        DW'(bus.count),        DW'(sz));
        check("empty",        DW'(bus.empty),        DW'(sz == 0));
        check("full",         DW'(bus.full),         DW'(sz == DEPTH));
        check("almost_empty", DW'(bus.almost_empty), DW'(sz <= AE));
        check("almost_full",  DW'(bus.almost_full),  DW'(sz >= AF));
        check("dataOut",      bus.dataOut,           mdl_dout);
`ifdef PARAM_SYNC_FIFO_ERR_EN
        check("overflow",     DW'(bus.overflow),     DW'(mdl_ovf));
        check("underflow",    DW'(bus.underflow),    DW'(mdl_unf));
`endif
    endtask

    // Inputs change after the falling edge; outputs are checked at the next falling edge.
    task automatic step(input logic rst_n, input logic rd, input logic wr,
                        input logic fl, input logic [DW-1:0] din);
        nRst       = rst_n;
        bus.read   = rd;
        bus.write  = wr;
        bus.flush  = fl;
        bus.dataIn = din;
        @(posedge clk);
        model_step(rst_n, rd, wr, fl, din);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        mdl_dout = '0;
        mdl_ovf  = 1'b0;
        mdl_unf  = 1'b0;
        nRst = 1'b1; bus.read = 1'b0; bus.write = 1'b0; bus.flush = 1'b0; bus.dataIn = '0;

        // reset
        step(1'b0, 1'b1, 1'b1, 1'b0, rep(8'hAA));
        check("rst_count", DW'(bus.count), DW'(0));
        check("rst_empty", DW'(bus.empty), DW'(1));
        check("rst_dout",  bus.dataOut,    DW'(0));

        // single transfer
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("single_cnt1", DW'(bus.count), DW'(1));
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("single_cnt0", DW'(bus.count), DW'(0));
        check("single_dout", bus.dataOut, DW'(0));

        // ordering
        step(1'b1, 1'b0, 1'b1, 1'b0, rep(8'h11));
        step(1'b1, 1'b0, 1'b1, 1'b0, rep(8'h22));
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("order_first",  bus.dataOut, rep(8'h11));
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("order_second", bus.dataOut, rep(8'h22));

        // fill, thresholds, dropped 9th write
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, rep(8'(i)));
            check("fill_af", DW'(bus.almost_full), DW'(i >= 7));
        end
        check("fill_full", DW'(bus.full), DW'(1));
        step(1'b1, 1'b0, 1'b1, 1'b0, rep(8'h09));
        check("drop_count", DW'(bus.count), DW'(8));
`ifdef PARAM_SYNC_FIFO_ERR_EN
        check("drop_ovf", DW'(bus.overflow), DW'(1));
`endif

        // read+write at full
        step(1'b1, 1'b1, 1'b1, 1'b0, rep(8'h0F));
        check("rw_full_dout",  bus.dataOut,    rep(8'h01));
        check("rw_full_count", DW'(bus.count), DW'(8));
        for (int i = 2; i <= 9; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0);
            check("drain_dout", bus.dataOut, (i <= 8) ? rep(8'(i)) : rep(8'h0F));
        end
        check("drain_empty", DW'(bus.empty), DW'(1));

        // empty read, then flush with write
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("empty_rd_dout", bus.dataOut, rep(8'h0F));
`ifdef PARAM_SYNC_FIFO_ERR_EN
        check("empty_rd_unf", DW'(bus.underflow), DW'(1));
`endif
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rep(8'hC0 + 8'(i)));
        step(1'b1, 1'b0, 1'b1, 1'b1, rep(8'hEE));
        check("flush_count", DW'(bus.count), DW'(0));
        check("flush_empty", DW'(bus.empty), DW'(1));
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("flush_nostore", bus.dataOut, rep(8'h0F));

        // both-at-empty: only the write is accepted, dataOut holds
        step(1'b1, 1'b1, 1'b1, 1'b0, rep(8'h5A));
        check("rw_empty_cnt",  DW'(bus.count), DW'(1));
        check("rw_empty_dout", bus.dataOut, rep(8'h0F));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_rd, r_wr, r_fl;
            logic [DW-1:0] r_d;
            r_rst = ($urandom_range(0, 199) != 0);
            r_fl  = ($urandom_range(0, 79) == 0);
            if ((i / 200) % 2 == 0) begin
                r_wr = ($urandom_range(0, 3) != 0);
                r_rd = ($urandom_range(0, 3) == 0);
            end else begin
                r_wr = ($urandom_range(0, 3) == 0);
                r_rd = ($urandom_range(0, 3) != 0);
            end
            r_d = {$urandom, $urandom, $urandom, $urandom};
            step(r_rst, r_rd, r_wr, r_fl, r_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised synchronous FIFO; next generation of the 128-bit, 8-deep block buffer.
- Sits between the AES block producer and consumer stages.
- Adds over the 8-deep block: configurable width and depth, an occupancy count, programmable almost-empty/almost-full thresholds, and a synchronous flush.
- dataOut is a registered read port; it updates only on an accepted read.

Parameters:
- DATA_WIDTH, 128: width of dataIn/dataOut in bits.
- DEPTH, 8: number of entries; must be a power of two and >= 2.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.
- AF_THRESH, 7: almost_full asserts when count >= AF_THRESH; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- nRst  in  1  reset: synchronous, active-low, sampled on rising clk.
- read  in  1  read request.
- write  in  1  write request; dataIn is captured when the write is accepted.
- flush  in  1  synchronous clear of FIFO contents.
- dataIn  in  DATA_WIDTH  write data.
- dataOut  out  DATA_WIDTH  registered read data.
- empty  out  1  high when count == 0.
- full  out  1  high when count == DEPTH.
- almost_empty  out  1  high when count <= AE_THRESH.
- almost_full  out  1  high when count >= AF_THRESH.
- count  out  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Reset (nRst low at a rising edge):
  - wr_ptr = rd_ptr = 0, count = 0, dataOut = 0.
  - Flags settle to empty=1, full=0, almost_empty=1, almost_full=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all contents; read, write and flush are ignored in that cycle.
- Flag timing: all flags decode combinationally from the count register, so they are valid in the same cycle count updates.
- Pointers: log2(DEPTH) bits wide; they wrap naturally from DEPTH-1 to 0. count is tracked separately and resolves full vs empty.
- Accept rules, evaluated at each rising edge, with nRst high and flush low:
  - rd_ok = read & ~empty.
  - wr_ok = write & (~full | read).
  - When full, a simultaneous read and write are both accepted and count stays at DEPTH.
  - When empty, a simultaneous read and write accept only the write. The read is ignored and dataOut holds; there is no fall-through.
- Write: on wr_ok, mem[wr_ptr] <= dataIn and wr_ptr increments.
- Read: on rd_ok, dataOut <= mem[rd_ptr] and rd_ptr increments.
  - Read latency is 1 clock: data is on dataOut after the edge where read is accepted.
  - dataOut holds its last value otherwise, including after the FIFO drains.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- Rejected requests: a write while full without read, or a read while empty, is dropped silently. Pointers, count and dataOut are unchanged.
- Flush (flush high at an edge): pointers and count go to 0 and dataOut holds. Flush overrides read and write in the same cycle; neither is accepted.

Optional Feature:
- Macro: PARAM_SYNC_FIFO_ERR_EN.
- Defined: adds two 1-bit outputs, overflow and underflow.
  - overflow sets on a rejected write (write & full & ~read).
  - underflow sets on a rejected read (read & empty).
  - Both are sticky; they clear only on reset or flush.
  - Reset value 0.
- Undefined: these ports and their logic do not exist, and dropped requests are invisible.

Test Plan:
- Reset: nRst low for 1 clk -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, dataOut=0.
- Single transfer: write 128'h0 for 1 clk, then read for 1 clk -> count goes 1 then 0; dataOut==0 one edge after the read.
- Ordering: write 0x11..11 then 0x22..22, then read on 2 consecutive clocks -> dataOut is 0x11..11 after the first edge and 0x22..22 after the second.
- Fill and threshold:
  - Write 0x1..01 through 0x8..08 on 8 consecutive clocks -> almost_full rises at count=7; full=1 at count=8.
  - A 9th write without read is dropped: count stays 8, and overflow=1 if PARAM_SYNC_FIFO_ERR_EN is defined.
- Read+write at full:
  - From the full state, read and write 0xF..0F together for 1 clk -> dataOut=0x1..01, count=8.
  - Then 8 more reads -> dataOut steps 0x2..02 through 0x8..08, then 0xF..0F; empty=1 at the end.
- Empty read and flush:
  - Read while empty -> dataOut unchanged, count=0, and underflow=1 if the macro is defined.
  - Write 3 entries, then assert flush together with write -> count=0, empty=1, nothing stored, error flags cleared.
